usb_ctrl_pio_out: RTL and testbench

//  Avalon-MM slave output port that drives the USB host controller's

---
 rtl/usb_pio_pkg.sv | 20 ++
 rtl/usb_ctrl_pio_out_if.sv | 20 ++
 rtl/usb_pio_pulse_timer.sv | 73 +++++++
 rtl/usb_ctrl_pio_out.sv | 85 ++++++++
 tb/tb_usb_ctrl_pio_out.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/usb_pio_pkg.sv
// Shared constants and types for the USB controller sideband PIO output port.
package usb_pio_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA   = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_RSVD1  = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_SET    = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_CLEAR  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_PMASK  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_PLEN   = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd6;

  typedef enum logic {
    P_IDLE   = 1'b0,
    P_ACTIVE = 1'b1
  } pulse_state_t;

endpackage

// File: rtl/usb_ctrl_pio_out_if.sv
// Avalon-MM slave bus bundle for the sideband PIO output port.
interface usb_ctrl_pio_out_if;
  import usb_pio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/usb_pio_pulse_timer.sv
// Hardware-timed pulse generator: snapshots the pulse mask and counts the
// pulse length down, exposing the inversion mask for the next cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   P_IDLE   | no pulse; cnt = 0; a start with len != 0 begins a pulse
//   P_ACTIVE | pulse running; cnt = cycles left including this one
module usb_pio_pulse_timer
  import usb_pio_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [WIDTH-1:0] mask,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic [WIDTH-1:0] inv_mask
);

  pulse_state_t     state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] act_mask, act_mask_nx;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    act_mask_nx = act_mask;
    case (state)
      P_IDLE: begin
        if (start && (len != '0)) begin
          state_nx    = P_ACTIVE;
          cnt_nx      = len;
          act_mask_nx = mask;
        end
      end
      P_ACTIVE: begin
        // Retriggers are ignored; the pulse always runs its original length.
        if (cnt == CNT_W'(1)) begin
          state_nx = P_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nx = P_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= P_IDLE;
      cnt      <= '0;
      act_mask <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      act_mask <= act_mask_nx;
    end
  end

  assign busy      = (state == P_ACTIVE);
  assign remaining = cnt;
  // Look-ahead so the top can register out_port in the same edge as the write.
  assign inv_mask  = (state_nx == P_ACTIVE) ? act_mask_nx : '0;

endmodule

// File: rtl/usb_ctrl_pio_out.sv
// Avalon-MM output port driving the USB host controller sideband pins, with
// atomic SET/CLEAR access and a hardware-timed pulse generator.
module usb_ctrl_pio_out
  import usb_pio_pkg::*;
#(
  parameter int               WIDTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  usb_ctrl_pio_out_if.slave bus,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]  data_reg, data_nx;
  logic [WIDTH-1:0]  pmask, pmask_nx;
  logic [WIDTH-1:0]  wd_w;
  logic [WIDTH-1:0]  inv_mask;
  logic [CNT_W-1:0]  remaining;
  logic [DATA_W-1:0] rd_nx;
  logic              wr;
  logic              start;
  logic              busy;
  logic              unused_wd_hi;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign wd_w         = bus.writedata[WIDTH-1:0];
  assign start        = wr && (bus.address == ADDR_PLEN);
  assign unused_wd_hi = ^bus.writedata;

  always_comb begin
    data_nx  = data_reg;
    pmask_nx = pmask;
    if (wr) begin
      case (bus.address)
        ADDR_DATA:  data_nx  = wd_w;
        ADDR_SET:   data_nx  = data_reg | wd_w;
        ADDR_CLEAR: data_nx  = data_reg & ~wd_w;
        ADDR_PMASK: pmask_nx = wd_w;
        default:    ;
      endcase
    end
  end

  always_comb begin
    rd_nx = '0;
    case (bus.address)
      ADDR_DATA:   rd_nx[WIDTH-1:0] = data_reg;
      ADDR_PMASK:  rd_nx[WIDTH-1:0] = pmask;
      ADDR_PLEN:   rd_nx[CNT_W-1:0] = remaining;
      ADDR_STATUS: rd_nx[0]         = busy;
      default:     ;
    endcase
  end

  usb_pio_pulse_timer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .len       (bus.writedata[CNT_W-1:0]),
    .mask      (pmask),
    .busy      (busy),
    .remaining (remaining),
    .inv_mask  (inv_mask)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg     <= RESET_VALUE;
      pmask        <= '0;
      out_port     <= RESET_VALUE;
      bus.readdata <= '0;
    end else begin
      data_reg     <= data_nx;
      pmask        <= pmask_nx;
      out_port     <= data_nx ^ inv_mask;
      bus.readdata <= rd_nx;
    end
  end

endmodule

// File: tb/tb_usb_ctrl_pio_out.sv
// Bench for usb_ctrl_pio_out: vector table, hand-written pulse corner cases
// and randomized traffic checked against a behavioural register/pulse model.
module tb_usb_ctrl_pio_out;
  import usb_pio_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] out_port;

  usb_ctrl_pio_out_if bus ();

  usb_ctrl_pio_out #(
    .WIDTH       (2),
    .RESET_VALUE (2'b01),
    .CNT_W       (16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model: remaining > 0 means a pulse is in progress.
  logic [1:0]  m_data, m_pmask, m_amask;
  int          m_rem;
  logic [1:0]  exp_out;
  logic [31:0] exp_rd;

  typedef struct {
    logic [2:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [1:0]  eo;
    logic [31:0] er;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data  = 2'b01;
    m_pmask = 2'b00;
    m_amask = 2'b00;
    m_rem   = 0;
    exp_out = 2'b01;
    exp_rd  = 32'h0;
  endtask

  task automatic model_step(input logic [2:0] a, input logic cs, input logic wn,
                            input logic [31:0] wd);
    bit wr;
    int len;
    wr  = cs && !wn;
    len = int'(wd & 32'hFFFF);
    case (a)
      3'd0:    exp_rd = {30'h0, m_data};
      3'd4:    exp_rd = {30'h0, m_pmask};
      3'd5:    exp_rd = 32'(m_rem);
      3'd6:    exp_rd = (m_rem > 0) ? 32'h1 : 32'h0;
      default: exp_rd = 32'h0;
    endcase
    if (m_rem > 0) m_rem = m_rem - 1;
    else if (wr && a == 3'd5 && len != 0) begin
      m_rem   = len;
      m_amask = m_pmask;
    end
    if (wr) begin
      case (a)
        3'd0: m_data  = wd[1:0];
        3'd2: m_data  = m_data | wd[1:0];
        3'd3: m_data  = m_data & ~wd[1:0];
        3'd4: m_pmask = wd[1:0];
        default: ;
      endcase
    end
    exp_out = m_data ^ ((m_rem > 0) ? m_amask : 2'b00);
  endtask

  task automatic cycle(input logic [2:0] a, input logic cs, input logic wn,
                       input logic [31:0] wd);
    bus.address    = a;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.writedata  = wd;
    @(posedge clk);
    model_step(a, cs, wn, wd);
    #1;
    chk("model_out", {30'h0, out_port}, {30'h0, exp_out});
    chk("model_rd", bus.readdata, exp_rd);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
    cycle(a, 1'b1, 1'b0, wd);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    cycle(a, 1'b0, 1'b1, 32'h0);
  endtask

  function automatic vec_t mk(input logic [2:0] a, input logic cs, input logic wn,
                              input logic [31:0] wd, input logic [1:0] eo,
                              input logic [31:0] er);
    vec_t v;
    v.addr = a; v.cs = cs; v.wn = wn; v.wd = wd; v.eo = eo; v.er = er;
    return v;
  endfunction

  initial begin
    int n_hi;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    model_reset();

    tbl.push_back(mk(3'd0, 0, 1, 32'h0,        2'b01, 32'h1));
    tbl.push_back(mk(3'd0, 1, 0, 32'h2,        2'b10, 32'h1));
    tbl.push_back(mk(3'd2, 1, 0, 32'h1,        2'b11, 32'h0));
    tbl.push_back(mk(3'd3, 1, 0, 32'h2,        2'b01, 32'h0));
    tbl.push_back(mk(3'd4, 1, 0, 32'h1,        2'b01, 32'h0));
    tbl.push_back(mk(3'd0, 1, 0, 32'h0,        2'b00, 32'h1));
    tbl.push_back(mk(3'd5, 1, 0, 32'h5,        2'b01, 32'h0));
    tbl.push_back(mk(3'd5, 0, 1, 32'h0,        2'b01, 32'h5));
    tbl.push_back(mk(3'd5, 0, 1, 32'h0,        2'b01, 32'h4));
    tbl.push_back(mk(3'd5, 0, 1, 32'h0,        2'b01, 32'h3));
    tbl.push_back(mk(3'd5, 0, 1, 32'h0,        2'b01, 32'h2));
    tbl.push_back(mk(3'd5, 0, 1, 32'h0,        2'b00, 32'h1));
    tbl.push_back(mk(3'd5, 0, 1, 32'h0,        2'b00, 32'h0));
    tbl.push_back(mk(3'd5, 1, 0, 32'h2,        2'b01, 32'h0));
    tbl.push_back(mk(3'd6, 0, 1, 32'h0,        2'b01, 32'h1));
    tbl.push_back(mk(3'd6, 0, 1, 32'h0,        2'b00, 32'h1));
    tbl.push_back(mk(3'd6, 0, 1, 32'h0,        2'b00, 32'h0));
    tbl.push_back(mk(3'd1, 1, 0, 32'hFFFFFFFF, 2'b00, 32'h0));
    tbl.push_back(mk(3'd7, 0, 1, 32'h0,        2'b00, 32'h0));
    tbl.push_back(mk(3'd0, 1, 0, 32'hFFFFFFFE, 2'b10, 32'h0));
    tbl.push_back(mk(3'd0, 0, 1, 32'h0,        2'b10, 32'h2));
    tbl.push_back(mk(3'd4, 0, 1, 32'h0,        2'b10, 32'h1));

    // Reset values
    #12;
    chk("reset_out", {30'h0, out_port}, 32'h1);
    chk("reset_rd", bus.readdata, 32'h0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      cycle(tbl[i].addr, tbl[i].cs, tbl[i].wn, tbl[i].wd);
      chk($sformatf("vec%0d_out", i), {30'h0, out_port}, {30'h0, tbl[i].eo});
      chk($sformatf("vec%0d_rd", i), bus.readdata, tbl[i].er);
    end

    // PLEN write during a pulse must neither retrigger nor extend it
    n_hi = 0;
    wr_reg(ADDR_PLEN, 32'd10);
    if (out_port[0]) n_hi++;
    wr_reg(ADDR_PLEN, 32'd3);
    if (out_port[0]) n_hi++;
    for (int i = 0; i < 14; i++) begin
      rd_reg(ADDR_STATUS);
      if (out_port[0]) n_hi++;
    end
    chk("pulse_len_no_retrigger", 32'(n_hi), 32'd10);
    wr_reg(ADDR_PLEN, 32'd0);
    chk("plen0_busy", {31'h0, dut.u_timer.busy}, 32'h0);
    rd_reg(ADDR_STATUS);
    chk("plen0_status", bus.readdata, 32'h0);

    // PMASK written mid-pulse applies only to the next pulse
    wr_reg(ADDR_DATA, 32'h0);
    wr_reg(ADDR_PLEN, 32'd6);
    wr_reg(ADDR_PMASK, 32'h3);
    chk("pmask_mid_pulse", {30'h0, out_port}, 32'h1);
    for (int i = 0; i < 6; i++) rd_reg(ADDR_STATUS);
    wr_reg(ADDR_PLEN, 32'd4);
    chk("pmask_next_pulse", {30'h0, out_port}, 32'h3);
    wr_reg(ADDR_SET, 32'h2);
    chk("set_during_pulse", {30'h0, out_port}, 32'h1);
    for (int i = 0; i < 5; i++) rd_reg(ADDR_STATUS);
    chk("after_pulse_out", {30'h0, out_port}, 32'h2);

    // Asynchronous reset mid-pulse
    wr_reg(ADDR_DATA, 32'h0);
    wr_reg(ADDR_PLEN, 32'd8);
    rd_reg(ADDR_STATUS);
    chk("pulse8_on", {30'h0, out_port}, 32'h3);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_out", {30'h0, out_port}, 32'h1);
    chk("async_rst_busy", {31'h0, dut.u_timer.busy}, 32'h0);
    chk("async_rst_rd", bus.readdata, 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold_out", {30'h0, out_port}, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) rd_reg(ADDR_STATUS);
    chk("no_resume_out", {30'h0, out_port}, 32'h1);
    rd_reg(ADDR_PLEN);
    chk("no_resume_cnt", bus.readdata, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = $urandom();
      if (a == ADDR_PLEN) d = (d & 32'hFFFF0000) | 32'($urandom_range(0, 9));
      cycle(a, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), d);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
